// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer.
//   - op encodings presented on the command interface
//   - FSM state encodings, also visible on the debug state output
//   - default datapath width
package alu_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_INC = 3'b001,
    OP_NEG = 3'b010,
    OP_SUB = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_router.sv
// Combinational operand/strobe router for the external ALU.
// Ports:
//   state      : current sequencer state
//   op         : latched op code
//   opnd_a/b   : latched operands A/B
//   mcand, acc : multiplicand and accumulator of the shift-and-add loop
//   mplier_lsb : current multiplier bit, selects whether a MUL step adds
//   alu_a/b    : ALU operand drives
//   alu_add/inc/neg/sub : ALU strobes, at most one high
// Every branch sets at most one strobe, so the one-hot-or-zero rule holds by
// construction; outside EXEC/MUL everything is driven to zero.
module alu_op_router
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  state_e             state,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   opnd_a,
  input  logic [WIDTH-1:0]   opnd_b,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   acc,
  input  logic               mplier_lsb,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_add,
  output logic               alu_inc,
  output logic               alu_neg,
  output logic               alu_sub
);

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_add = 1'b0;
    alu_inc = 1'b0;
    alu_neg = 1'b0;
    alu_sub = 1'b0;
    case (state)
      ST_EXEC: begin
        case (op)
          OP_ADD: begin
            alu_a   = opnd_a;
            alu_b   = opnd_b;
            alu_add = 1'b1;
          end
          OP_INC: begin
            // ALU increments its B input.
            alu_b   = opnd_a;
            alu_inc = 1'b1;
          end
          OP_NEG: begin
            alu_a   = opnd_a;
            alu_neg = 1'b1;
          end
          OP_SUB: begin
            // ALU computes B-A, so swap to get opa-opb.
            alu_a   = opnd_b;
            alu_b   = opnd_a;
            alu_sub = 1'b1;
          end
          default: ; // illegal op: no strobes
        endcase
      end
      ST_MUL: begin
        alu_a   = mcand;
        alu_b   = acc;
        alu_add = mplier_lsb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning the external combinational 32-bit ALU. Accepts one
// command at a time on start/op/opa/opb, runs single-cycle ADD/INC/NEG/SUB
// or a shift-and-add MUL over repeated ALU ADD passes, and returns a
// registered result with Z/N flags plus a one-cycle done pulse.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   start, op, opa, opb : command request (sampled only when idle)
//   busy, done        : in-flight indicator, one-cycle completion pulse
//   result, flag_z, flag_n : registered result and flags
//   alu_a, alu_b, alu_add/inc/neg/sub : ALU drives
//   alu_out, alu_z, alu_n : ALU response
//   dbg_state         : current FSM state
// Build option: define MUL_EARLY_EXIT_EN to end MUL as soon as the remaining
// multiplier bits are zero; otherwise MUL always runs WIDTH steps.
// Handshake: start is a level request seen only in IDLE; the edge where it
// is seen accepts the command and latches op/opa/opb. Requests while busy
// are dropped, not queued. done is high for exactly one cycle with
// result/flags already valid, and busy falls at the end of that cycle.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_add,
  output logic             alu_inc,
  output logic             alu_neg,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  output state_e           dbg_state
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_n_q, flag_n_d;

  logic [WIDTH-1:0]   mplier_nxt;
  logic [WIDTH-1:0]   acc_nxt;
  logic               mul_last;

  // MUL step values shared by the next-state and datapath logic.
  always_comb begin
    mplier_nxt = mplier_q >> 1;
    acc_nxt    = mplier_q[0] ? alu_out : acc_q;
`ifdef MUL_EARLY_EXIT_EN
    // mplier_q==0 implies mplier_nxt==0, so this also covers the
    // "nothing left to add" exit.
    mul_last = (count_q == CNT_W'(WIDTH - 1)) || (mplier_nxt == '0);
`else
    mul_last = (count_q == CNT_W'(WIDTH - 1));
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Datapath next values.
  always_comb begin
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          opa_d    = opa;
          opb_d    = opb;
          mcand_d  = opa;
          mplier_d = opb;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      ST_EXEC: begin
        // EXEC only sees op codes 000..011 or illegal 101..111; the legal
        // single-cycle ops are exactly those with op[2]==0.
        if (!op_q[2]) begin
          result_d = alu_out;
          flag_z_d = alu_z;
          flag_n_d = alu_n;
        end
      end
      ST_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nxt;
        acc_d    = acc_nxt;
        count_d  = count_q + CNT_W'(1);
        if (mul_last) begin
          result_d = acc_nxt;
          flag_z_d = (acc_nxt == '0);
          flag_n_d = acc_nxt[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;

  alu_op_router #(.WIDTH(WIDTH)) u_router (
    .state      (state_q),
    .op         (op_q),
    .opnd_a     (opa_q),
    .opnd_b     (opb_q),
    .mcand      (mcand_q),
    .acc        (acc_q),
    .mplier_lsb (mplier_q[0]),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_add    (alu_add),
    .alu_inc    (alu_inc),
    .alu_neg    (alu_neg),
    .alu_sub    (alu_sub)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl with a behavioural model of the external ALU.
// Expected {flag_n, flag_z, result} entries are queued at command issue and
// popped when done is seen.
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa, opb;
  logic         busy, done;
  logic [W-1:0] result;
  logic         flag_z, flag_n;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_add, alu_inc, alu_neg, alu_sub;
  logic [W-1:0] alu_out;
  logic         alu_z, alu_n;
  state_e       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_res = '0;
  logic         last_z   = 1'b0;
  logic         last_n   = 1'b0;

  alu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_add   (alu_add),
    .alu_inc   (alu_inc),
    .alu_neg   (alu_neg),
    .alu_sub   (alu_sub),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .dbg_state (dbg_state)
  );

  // External ALU model.
  always_comb begin
    if (alu_add)      alu_out = alu_a + alu_b;
    else if (alu_inc) alu_out = alu_b + 1;
    else if (alu_neg) alu_out = -alu_a;
    else              alu_out = alu_b - alu_a;
    alu_z = (alu_out == '0);
    alu_n = alu_out[W-1];
  end

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_fail(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    errors++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  // Pop one scoreboard entry and compare it with the registered outputs.
  task automatic check_result();
    logic [W+1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      chk_fail("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (result !== e[W-1:0]) chk_fail("result", result, e[W-1:0]);
      checks++;
      if (flag_z !== e[W]) chk_fail("flag_z", flag_z, e[W]);
      checks++;
      if (flag_n !== e[W+1]) chk_fail("flag_n", flag_n, e[W+1]);
    end
  endtask

  // Issue one command, then follow it through to done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         z, n;
    logic [3:0]   stb;
    int           lat, k;
    case (o)
      3'b000:  r = a + b;
      3'b001:  r = a + 1;
      3'b010:  r = -a;
      3'b011:  r = a - b;
      3'b100:  r = a * b;
      default: r = last_res;
    endcase
    if (o > 3'b100) begin
      z = last_z;
      n = last_n;
    end else begin
      z = (r == '0);
      n = r[W-1];
    end
    case (o)
      3'b000:  stb = 4'b1000;
      3'b001:  stb = 4'b0100;
      3'b010:  stb = 4'b0010;
      3'b011:  stb = 4'b0001;
      3'b100:  stb = {b[0], 3'b000};
      default: stb = 4'b0000;
    endcase
    lat = (o == 3'b100) ? mul_lat(b) : 1;
    exp_q.push_back({n, z, r});
    last_res = r;
    last_z   = z;
    last_n   = n;

    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    opa = $urandom;
    opb = $urandom;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) chk_fail("busy_after_accept", busy, 1);
    checks++;
    if ({alu_add, alu_inc, alu_neg, alu_sub} !== stb)
      chk_fail("strobes_first", {alu_add, alu_inc, alu_neg, alu_sub}, stb);
    if (o == 3'b000 || o == 3'b010 || o == 3'b100) begin
      checks++;
      if (alu_a !== a) chk_fail("alu_a_first", alu_a, a);
    end
    if (o == 3'b011) begin
      checks++;
      if (alu_a !== b) chk_fail("alu_a_first", alu_a, b);
    end
    if (o == 3'b000) begin
      checks++;
      if (alu_b !== b) chk_fail("alu_b_first", alu_b, b);
    end
    if (o == 3'b001 || o == 3'b011) begin
      checks++;
      if (alu_b !== a) chk_fail("alu_b_first", alu_b, a);
    end
    if (o == 3'b100) begin
      checks++;
      if (alu_b !== {W{1'b0}}) chk_fail("alu_b_first", alu_b, 0);
    end
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== lat) chk_fail("latency", k, lat);
    check_result();
    checks++;
    if ({alu_add, alu_inc, alu_neg, alu_sub} !== 4'b0000)
      chk_fail("strobes_at_done", {alu_add, alu_inc, alu_neg, alu_sub}, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) chk_fail("done_one_cycle", done, 0);
    checks++;
    if (busy !== 1'b0) chk_fail("busy_after_done", busy, 0);
  endtask

  initial begin : main
    int dones;
    int k;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 3'b000; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) chk_fail("rst_busy", busy, 0);
    checks++;
    if (done !== 1'b0) chk_fail("rst_done", done, 0);
    checks++;
    if (result !== {W{1'b0}}) chk_fail("rst_result", result, 0);
    checks++;
    if ({flag_z, flag_n} !== 2'b00) chk_fail("rst_flags", {flag_z, flag_n}, 0);
    checks++;
    if ({alu_a, alu_b} !== {2*W{1'b0}}) chk_fail("rst_alu_ab", {alu_a, alu_b}, 0);
    checks++;
    if ({alu_add, alu_inc, alu_neg, alu_sub} !== 4'b0000)
      chk_fail("rst_strobes", {alu_add, alu_inc, alu_neg, alu_sub}, 0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) chk_fail("idle_no_start", busy, 0);

    // Single-cycle ops.
    run_op(3'b000, 32'd5, 32'd7);
    run_op(3'b011, 32'd3, 32'd5);
    run_op(3'b001, 32'hFFFF_FFFF, 32'd9);
    run_op(3'b010, 32'd1, 32'd0);
    run_op(3'b110, 32'd4, 32'd4);
    run_op(3'b011, 32'd9, 32'd9);

    // Multiply.
    run_op(3'b100, 32'd6, 32'd7);
    run_op(3'b100, 32'd6, 32'd0);
    run_op(3'b100, 32'h0001_0000, 32'h0001_0000);
    run_op(3'b100, 32'hFFFF_FFFD, 32'd4);
    run_op(3'b100, 32'd1, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 4095);
      run_op(3'b100, ra, rb);
    end

    // start re-asserted during MUL must be ignored.
    exp_q.push_back({1'b0, 1'b0, 32'd42});
    @(negedge clk);
    start = 1'b1; op = 3'b100; opa = 32'd6; opb = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b000; opa = 32'd100; opb = 32'd200;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check_result();
      end
    end
    checks++;
    if (dones !== 1) chk_fail("single_done_pulse", dones, 1);
    checks++;
    if (busy !== 1'b0) chk_fail("idle_after_ignore", busy, 0);

    // Reset in the middle of a long MUL.
    @(negedge clk);
    start = 1'b1; op = 3'b100; opa = 32'd6; opb = 32'h00FF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) chk_fail("mul_running", busy, 1);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) chk_fail("abort_busy", busy, 0);
    checks++;
    if (done !== 1'b0) chk_fail("abort_done", done, 0);
    checks++;
    if (result !== {W{1'b0}}) chk_fail("abort_result", result, 0);
    checks++;
    if ({flag_z, flag_n} !== 2'b00) chk_fail("abort_flags", {flag_z, flag_n}, 0);
    checks++;
    if ({alu_a, alu_b} !== {2*W{1'b0}}) chk_fail("abort_alu_ab", {alu_a, alu_b}, 0);
    checks++;
    if ({alu_add, alu_inc, alu_neg, alu_sub} !== 4'b0000)
      chk_fail("abort_strobes", {alu_add, alu_inc, alu_neg, alu_sub}, 0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0; last_z = 1'b0; last_n = 1'b0;
    dones = 0;
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) k++;
    end
    checks++;
    if (dones !== 0) chk_fail("no_done_after_abort", dones, 0);
    checks++;
    if (k !== 0) chk_fail("no_busy_after_abort", k, 0);
    run_op(3'b000, 32'd1, 32'd1);

    checks++;
    if (exp_q.size() !== 0) chk_fail("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

endmodule
